// File: rtl/comma_align_n.sv
// Comma-based byte lane aligner: finds the K-character offset, locks after LOCK_CNT hits, realigns data.
// Optional lock-entry counter on realign_cnt_o when COMMA_ALIGN_STATS_EN is defined.
module comma_align_n #(
  parameter int          NBYTES     = 2,
  parameter logic [7:0]  COMMA      = 8'h3C,
  parameter int          LOCK_CNT   = 3,
  parameter int          UNLOCK_CNT = 2
) (
  input  logic                        ser_rx_clk_i,
  input  logic                        ser_rx_rst_i,
  input  logic [8*NBYTES-1:0]         ser_r_i,
  input  logic [NBYTES-1:0]           ser_rk_i,
  output logic [8*NBYTES-1:0]         ser_r_o,
  output logic [NBYTES-1:0]           ser_rk_o,
  output logic                        locked_o,
  output logic [$clog2(NBYTES)-1:0]   offset_o,
  output logic                        realign_o,
  output logic [15:0]                 realign_cnt_o
);
  localparam int KW = $clog2(NBYTES);
  localparam logic [3:0] LOCK_C   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_CNT);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t              state_reg, state_next;
  logic [3:0]          match_reg, match_next;
  logic [3:0]          miss_reg, miss_next;
  logic [KW-1:0]       cand_reg, cand_next;
  logic [KW-1:0]       k_reg, k_next;
  logic                realign_reg, realign_next;
  logic [8*NBYTES-1:0] s1_r, s2_r, r_reg, r_next;
  logic [NBYTES-1:0]   s1_rk, s2_rk, rk_reg, rk_next;
  logic [NBYTES-1:0]   hit;
  logic                found;
  logic [KW-1:0]       c;
  logic                restart, lock_now;

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_hit
      assign hit[gi] = s1_rk[gi] && (s1_r[8*gi +: 8] == COMMA);
    end
  endgenerate

  // Lowest comma index wins, so scan from the top down.
  always_comb begin
    found = |hit;
    c     = '0;
    for (int j = NBYTES - 1; j >= 0; j--) begin
      if (hit[j]) c = KW'(j);
    end
  end

  always_ff @(posedge ser_rx_clk_i) begin
    if (ser_rx_rst_i) begin
      state_reg   <= HUNT;
      match_reg   <= '0;
      miss_reg    <= '0;
      cand_reg    <= '0;
      k_reg       <= '0;
      realign_reg <= 1'b0;
      s1_r        <= '0;
      s1_rk       <= '0;
      s2_r        <= '0;
      s2_rk       <= '0;
      r_reg       <= '0;
      rk_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      match_reg   <= match_next;
      miss_reg    <= miss_next;
      cand_reg    <= cand_next;
      k_reg       <= k_next;
      realign_reg <= realign_next;
      s1_r        <= ser_r_i;
      s1_rk       <= ser_rk_i;
      s2_r        <= s1_r;
      s2_rk       <= s1_rk;
      r_reg       <= r_next;
      rk_reg      <= rk_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    match_next   = match_reg;
    miss_next    = miss_reg;
    cand_next    = cand_reg;
    k_next       = k_reg;
    realign_next = 1'b0;
    restart      = 1'b0;
    lock_now     = 1'b0;
    if (found) begin
      case (state_reg)
        HUNT: restart = 1'b1;
        VERIFY: begin
          if (c == cand_reg) begin
            if (match_reg + 4'd1 == LOCK_C) lock_now = 1'b1;
            else                            match_next = match_reg + 4'd1;
          end else begin
            restart = 1'b1;
          end
        end
        LOCKED: begin
          if (c == k_reg)                          miss_next = '0;
          else if (miss_reg + 4'd1 == UNLOCK_C)    restart   = 1'b1;
          else                                     miss_next = miss_reg + 4'd1;
        end
        default: state_next = HUNT;
      endcase
    end
    if (restart) begin
      cand_next  = c;
      match_next = 4'd1;
      if (LOCK_CNT == 1) lock_now = 1'b1;
      else               state_next = VERIFY;
    end
    // In VERIFY c equals cand_reg when locking, so c is always the new offset.
    if (lock_now) begin
      state_next   = LOCKED;
      cand_next    = c;
      k_next       = c;
      miss_next    = '0;
      realign_next = 1'b1;
    end
  end

  // Output byte i comes from the older word when i+k fits, otherwise from the newer one.
  always_comb begin
    r_next  = '0;
    rk_next = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (i + int'(k_reg) < NBYTES) begin
        r_next[8*i +: 8] = s2_r[8*(i + int'(k_reg)) +: 8];
        rk_next[i]       = s2_rk[i + int'(k_reg)];
      end else begin
        r_next[8*i +: 8] = s1_r[8*(i + int'(k_reg) - NBYTES) +: 8];
        rk_next[i]       = s1_rk[i + int'(k_reg) - NBYTES];
      end
    end
  end

  always_comb begin
    ser_r_o   = r_reg;
    ser_rk_o  = rk_reg;
    locked_o  = (state_reg == LOCKED);
    offset_o  = k_reg;
    realign_o = realign_reg;
  end

`ifdef COMMA_ALIGN_STATS_EN
  logic [15:0] realign_cnt_reg;
  always_ff @(posedge ser_rx_clk_i) begin
    if (ser_rx_rst_i)                                 realign_cnt_reg <= '0;
    else if (realign_reg && realign_cnt_reg != 16'hFFFF) realign_cnt_reg <= realign_cnt_reg + 16'd1;
  end
  assign realign_cnt_o = realign_cnt_reg;
`else
  assign realign_cnt_o = 16'h0000;
`endif

endmodule
